// File: rtl/uart_host_bridge_if.sv
// FIFO-side handshake between the UART bridge and the command/memory top block.
// master = bridge side, slave = FIFO side.
interface uart_host_bridge_if;
    logic       o_data_valid;
    logic [7:0] o_data;
    logic       i_input_full;
    logic [7:0] i_data;
    logic       i_output_empty;
    logic       o_data_read;

    modport master (
        output o_data_valid, o_data, o_data_read,
        input  i_input_full, i_data, i_output_empty
    );

    modport slave (
        input  o_data_valid, o_data, o_data_read,
        output i_input_full, i_data, i_output_empty
    );
endinterface

// File: rtl/uart_host_bridge.sv
// 8N1 UART bridge: RX pushes bytes into the input FIFO, TX drains the output FIFO.
// Both FSMs use IDLE/START/DATA/STOP:
//   state | RX meaning                          | TX meaning
//   IDLE  | wait for synchronised 1->0 edge     | pop when FIFO non-empty
//   START | confirm start bit at mid-bit        | drive start bit (0)
//   DATA  | sample 8 bits LSB first             | drive 8 bits LSB first
//   STOP  | check stop bit / wait out a break   | drive stop bit (1)
module uart_host_bridge #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_BITS     = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_uart_rx,
    output logic                o_uart_tx,
    output logic                o_tx_busy,
    output logic [CNT_BITS-1:0] o_frame_err_count,
    output logic [CNT_BITS-1:0] o_overrun_count,
    uart_host_bridge_if.master  fifo
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    rx_state_t        rx_state_q, rx_state_d;
    logic             rx_s1_q, rx_s2_q, rx_prev_q;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q;
    logic [7:0]       rx_sr_q;
    logic             rx_brk_q, rx_brk_d;
    logic             rx_shift, rx_push, rx_ovr, rx_ferr;

    tx_state_t        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q;
    logic [9:0]       tx_sr_q;
    logic             tx_load, tx_shift;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_state_q <= RX_IDLE;
            tx_state_q <= TX_IDLE;
        end else begin
            rx_state_q <= rx_state_d;
            tx_state_q <= tx_state_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = (rx_cnt_q == LAST) ? '0 : rx_cnt_q + 1'b1;
        rx_brk_d   = rx_brk_q;
        rx_shift   = 1'b0;
        rx_push    = 1'b0;
        rx_ovr     = 1'b0;
        rx_ferr    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_s2_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt_q == HALF) begin
                    if (!rx_s2_q) begin
                        rx_state_d = RX_DATA;
                        rx_cnt_d   = '0;
                    end else begin
                        rx_state_d = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == LAST) begin
                    rx_shift = 1'b1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                // A held break is counted once, then we wait for the line to recover.
                if (rx_brk_q) begin
                    if (rx_s2_q) begin
                        rx_state_d = RX_IDLE;
                        rx_brk_d   = 1'b0;
                    end
                end else if (rx_cnt_q == LAST) begin
                    if (rx_s2_q) begin
                        rx_state_d = RX_IDLE;
                        rx_ovr     = fifo.i_input_full;
                        rx_push    = !fifo.i_input_full;
                    end else begin
                        rx_ferr  = 1'b1;
                        rx_brk_d = 1'b1;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_s1_q           <= 1'b1;
            rx_s2_q           <= 1'b1;
            rx_prev_q         <= 1'b1;
            rx_cnt_q          <= '0;
            rx_bit_q          <= '0;
            rx_sr_q           <= '0;
            rx_brk_q          <= 1'b0;
            fifo.o_data_valid <= 1'b0;
            fifo.o_data       <= '0;
            o_frame_err_count <= '0;
            o_overrun_count   <= '0;
        end else begin
            rx_s1_q           <= i_uart_rx;
            rx_s2_q           <= rx_s1_q;
            rx_prev_q         <= rx_s2_q;
            rx_cnt_q          <= rx_cnt_d;
            rx_brk_q          <= rx_brk_d;
            fifo.o_data_valid <= rx_push;
            if (rx_state_q == RX_IDLE) rx_bit_q <= '0;
            else if (rx_shift)         rx_bit_q <= rx_bit_q + 1'b1;
            if (rx_shift) rx_sr_q <= {rx_s2_q, rx_sr_q[7:1]};
            if (rx_push)  fifo.o_data <= rx_sr_q;
            if (rx_ferr && !(&o_frame_err_count)) o_frame_err_count <= o_frame_err_count + 1'b1;
            if (rx_ovr && !(&o_overrun_count))    o_overrun_count   <= o_overrun_count + 1'b1;
        end
    end

    always_comb begin
        tx_state_d       = tx_state_q;
        tx_cnt_d         = (tx_cnt_q == LAST) ? '0 : tx_cnt_q + 1'b1;
        tx_load          = 1'b0;
        tx_shift         = 1'b0;
        fifo.o_data_read = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (!fifo.i_output_empty) begin
                    fifo.o_data_read = 1'b1;
                    tx_load          = 1'b1;
                    tx_state_d       = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == LAST) begin
                    tx_shift   = 1'b1;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == LAST) begin
                    tx_shift = 1'b1;
                    if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == LAST) begin
                    tx_shift   = 1'b1;
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Whole frame lives in tx_sr_q; its LSB is the line, so the output is glitch-free.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            tx_sr_q  <= '1;
        end else begin
            tx_cnt_q <= tx_cnt_d;
            if (tx_state_q == TX_IDLE)             tx_bit_q <= '0;
            else if (tx_shift && tx_state_q == TX_DATA) tx_bit_q <= tx_bit_q + 1'b1;
            if (tx_load)       tx_sr_q <= {1'b1, fifo.i_data, 1'b0};
            else if (tx_shift) tx_sr_q <= {1'b1, tx_sr_q[9:1]};
        end
    end

    assign o_uart_tx = tx_sr_q[0];
    assign o_tx_busy = (tx_state_q != TX_IDLE);
endmodule

// File: tb/tb_uart_host_bridge.sv
// Directed bench for uart_host_bridge: RX framing/overrun/glitch, TX waveform and spacing, reset abort.
module tb_uart_host_bridge;
    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_uart_rx = 1'b1;
    logic       o_uart_tx;
    logic       o_tx_busy;
    logic [7:0] o_frame_err_count;
    logic [7:0] o_overrun_count;

    uart_host_bridge_if fifo_if ();

    uart_host_bridge #(.CLKS_PER_BIT(16), .CNT_BITS(8)) dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_uart_rx         (i_uart_rx),
        .o_uart_tx         (o_uart_tx),
        .o_tx_busy         (o_tx_busy),
        .o_frame_err_count (o_frame_err_count),
        .o_overrun_count   (o_overrun_count),
        .fifo              (fifo_if.master)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rd_count = 0, rd_cyc_last = 0, rd_cyc_prev = 0;
    int vld_count = 0, vld_cyc = 0;
    logic [7:0] vld_data = '0;
    int busy_cycles = 0;
    int start_cyc = 0;

    logic [7:0] tx_mem [0:3];
    int tx_head = 0;
    int tx_tail = 0;

    always_comb begin
        fifo_if.i_output_empty = (tx_head == tx_tail);
        fifo_if.i_data         = tx_mem[tx_head[1:0]];
    end

    always @(posedge i_clk) begin
        cyc <= cyc + 1;
        if (fifo_if.o_data_read) tx_head <= tx_head + 1;
    end

    always @(negedge i_clk) begin
        if (fifo_if.o_data_read) begin
            rd_count    <= rd_count + 1;
            rd_cyc_prev <= rd_cyc_last;
            rd_cyc_last <= cyc;
        end
        if (fifo_if.o_data_valid) begin
            vld_count <= vld_count + 1;
            vld_data  <= fifo_if.o_data;
            vld_cyc   <= cyc;
        end
        if (o_tx_busy) busy_cycles <= busy_cycles + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_mem[tx_tail[1:0]] = b;
        tx_tail++;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        tick(1);
        start_cyc = cyc;
        i_uart_rx = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            i_uart_rx = b[i];
            tick(16);
        end
        i_uart_rx = stop_bit;
        tick(16);
    endtask

    int         vb, rb, bb;
    logic [9:0] exp_line;

    initial begin
        fifo_if.i_input_full = 1'b0;
        for (int i = 0; i < 4; i++) tx_mem[i] = '0;
        tick(3);
        check_eq("rst_tx_line", o_uart_tx, 1'b1);
        check_eq("rst_valid", fifo_if.o_data_valid, 1'b0);
        check_eq("rst_data", fifo_if.o_data, 8'h00);
        check_eq("rst_read", fifo_if.o_data_read, 1'b0);
        check_eq("rst_busy", o_tx_busy, 1'b0);
        check_eq("rst_ferr", o_frame_err_count, 8'd0);
        check_eq("rst_ovr", o_overrun_count, 8'd0);
        i_rst_n = 1'b1;
        tick(5);

        // RX 0xA5; push lands 2 sync + 1 detect + 8 half-bit + 9*16 = 155 cycles after the start edge
        vb = vld_count;
        send_rx(8'hA5, 1'b1);
        tick(20);
        check_eq("rx_a5_pulses", vld_count - vb, 1);
        check_eq("rx_a5_data", vld_data, 8'hA5);
        check_eq("rx_a5_latency", vld_cyc - start_cyc, 155);
        check_eq("rx_a5_ferr", o_frame_err_count, 8'd0);
        check_eq("rx_a5_ovr", o_overrun_count, 8'd0);

        // TX 0x3C, line sampled at bit centres
        rb = rd_count;
        bb = busy_cycles;
        exp_line = 10'b1001111000;
        push_tx(8'h3C);
        #1;
        check_eq("tx_read_strobe", fifo_if.o_data_read, 1'b1);
        @(posedge i_clk);
        tick(8);
        for (int b = 0; b < 10; b++) begin
            check_eq($sformatf("tx_3c_bit%0d", b), o_uart_tx, exp_line[b]);
            if (b < 9) tick(16);
        end
        tick(9);
        check_eq("tx_3c_busy_end", o_tx_busy, 1'b0);
        check_eq("tx_3c_busy_len", busy_cycles - bb, 160);
        check_eq("tx_3c_reads", rd_count - rb, 1);

        // Back-to-back TX
        rb = rd_count;
        push_tx(8'h01);
        push_tx(8'h02);
        tick(340);
        check_eq("tx_b2b_reads", rd_count - rb, 2);
        check_eq("tx_b2b_spacing", rd_cyc_last - rd_cyc_prev, 161);
        check_eq("tx_b2b_idle", o_uart_tx, 1'b1);

        // Overrun
        vb = vld_count;
        fifo_if.i_input_full = 1'b1;
        send_rx(8'h55, 1'b1);
        tick(5);
        check_eq("ovr_no_push", vld_count - vb, 0);
        check_eq("ovr_count", o_overrun_count, 8'd1);
        fifo_if.i_input_full = 1'b0;
        send_rx(8'h66, 1'b1);
        tick(5);
        check_eq("ovr_66_push", vld_count - vb, 1);
        check_eq("ovr_66_data", vld_data, 8'h66);
        check_eq("ovr_count_hold", o_overrun_count, 8'd1);

        // Framing error with 40-bit break
        vb = vld_count;
        send_rx(8'h81, 1'b0);
        tick(640);
        check_eq("ferr_no_push", vld_count - vb, 0);
        check_eq("ferr_count", o_frame_err_count, 8'd1);
        i_uart_rx = 1'b1;
        tick(32);
        send_rx(8'h7E, 1'b1);
        tick(5);
        check_eq("ferr_7e_push", vld_count - vb, 1);
        check_eq("ferr_7e_data", vld_data, 8'h7E);
        check_eq("ferr_count_hold", o_frame_err_count, 8'd1);

        // 3-cycle glitch
        vb = vld_count;
        i_uart_rx = 1'b0;
        tick(3);
        i_uart_rx = 1'b1;
        tick(200);
        check_eq("glitch_no_push", vld_count - vb, 0);
        check_eq("glitch_ferr", o_frame_err_count, 8'd1);
        check_eq("glitch_ovr", o_overrun_count, 8'd1);

        // Reset mid TX frame
        push_tx(8'hAA);
        tick(50);
        check_eq("rst_mid_busy_before", o_tx_busy, 1'b1);
        i_rst_n = 1'b0;
        #1;
        check_eq("rst_mid_tx_line", o_uart_tx, 1'b1);
        check_eq("rst_mid_busy", o_tx_busy, 1'b0);
        check_eq("rst_mid_ovr", o_overrun_count, 8'd0);
        tick(3);
        i_rst_n = 1'b1;
        rb = rd_count;
        tick(200);
        check_eq("rst_no_read", rd_count - rb, 0);
        check_eq("rst_idle_line", o_uart_tx, 1'b1);
        push_tx(8'h5A);
        tick(5);
        check_eq("rst_then_read", rd_count - rb, 1);
        check_eq("rst_then_busy", o_tx_busy, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
